// File: rtl/sevenseg_scan_driver.sv
// Multiplexed driver for a common-anode seven-segment display: shadow register,
// per-slot digit scan with dead time, blink and leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    scan_tick
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_DEAD  = PRE_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRM_W-1:0]        frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic [NUM_DIGITS-1:0]   lz_run_s;
    logic [3:0]              code_s;
    logic                    blink_s;
    logic                    lz_s;
    logic                    blank_s;

    function automatic logic [6:0] decode_glyph(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b1111111;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Scan timing: prescaler, digit index, frame counter and blink phase.
    always_comb begin
        slot_end_s  = (pre_q == PRE_LAST);
        frame_end_s = slot_end_s && (idx_q == IDX_LAST);
        pre_d       = pre_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        phase_d     = phase_q;
        shadow_d    = shadow_q;

        if (load) begin
            shadow_d = digits_in;
        end else begin
            shadow_d = shadow_q;
        end

        if (slot_end_s) begin
            pre_d = {PRE_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
            idx_d = idx_q;
        end

        if (frame_end_s) begin
            if (frame_q == FRM_LAST) begin
                frame_d = {FRM_W{1'b0}};
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
                phase_d = phase_q;
            end
        end else begin
            frame_d = frame_q;
            phase_d = phase_q;
        end
    end

    // Digit selection and blanking; lz_run_s[i] means digit i and all above are zero.
    always_comb begin
        lz_run_s = {NUM_DIGITS{1'b0}};
        lz_run_s[NUM_DIGITS-1] = (shadow_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_run_s[i] = lz_run_s[i+1] & (shadow_q[4*i +: 4] == 4'h0);
        end

        code_s  = 4'h0;
        blink_s = 1'b0;
        lz_s    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_s[i] = (idx_q == IDX_W'(i));
            code_s   = code_s | ({4{sel_s[i]}} & shadow_q[4*i +: 4]);
            blink_s  = blink_s | (sel_s[i] & blink_mask[i]);
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_s = lz_s | (sel_s[i] & lz_run_s[i]);
        end

        blank_s = (code_s == 4'hF) | (blink_s & phase_q) | (lz_blank & lz_s);

        if (blank_s) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = decode_glyph(code_s);
        end

        if (pre_q < PRE_DEAD) begin
            an_d = {NUM_DIGITS{1'b1}};
        end else begin
            an_d = ~sel_s;
        end

        tick_d = slot_end_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {(4*NUM_DIGITS){1'b1}};
            pre_q    <= {PRE_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            frame_q  <= {FRM_W{1'b0}};
            phase_q  <= 1'b0;
            seg_q    <= 7'h7F;
            an_q     <= {NUM_DIGITS{1'b1}};
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg_n     = seg_q;
    assign an_n      = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with N=4, DIV=8, DEAD=2, BLINK_FRAMES=2.
module tb_sevenseg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        scan_tick;

    int n_checks;
    int n_fail;

    logic [3:0] an_tab   [4];
    logic [6:0] g1234    [4];
    logic [6:0] g5678    [4];

    sevenseg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .load      (load),
        .blink_mask(blink_mask),
        .lz_blank  (lz_blank),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered one sample after the second edge of a slot; leaves at the same point of the next slot.
    task automatic check_slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        check({tag, "/dead_an"}, 16'(an_n), 16'hF);
        check({tag, "/dead_seg"}, 16'(seg_n), 16'(seg_e));
        adv(1);
        check({tag, "/on_an"}, 16'(an_n), 16'(an_e));
        adv(5);
        check({tag, "/end_an"}, 16'(an_n), 16'(an_e));
        check({tag, "/end_seg"}, 16'(seg_n), 16'(seg_e));
        check({tag, "/tick"}, 16'(scan_tick), 16'h1);
        adv(1);
        check({tag, "/tick_lo"}, 16'(scan_tick), 16'h0);
        check({tag, "/wrap_an"}, 16'(an_n), 16'hF);
        adv(1);
    endtask

    task automatic restart(input string tag, input logic [15:0] data);
        reset = 1'b1;
        load  = 1'b0;
        adv(1);
        check({tag, "/rst_an"}, 16'(an_n), 16'hF);
        check({tag, "/rst_seg"}, 16'(seg_n), 16'h7F);
        check({tag, "/rst_tick"}, 16'(scan_tick), 16'h0);
        reset     = 1'b0;
        load      = 1'b1;
        digits_in = data;
        adv(1);
        load = 1'b0;
        check({tag, "/e1_an"}, 16'(an_n), 16'hF);
        check({tag, "/e1_seg"}, 16'(seg_n), 16'h7F);
        adv(1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        load       = 1'b0;
        digits_in  = 16'h0000;
        blink_mask = 4'h0;
        lz_blank   = 1'b0;
        an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        g1234  = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        g5678  = '{7'h00, 7'h0F, 7'h20, 7'h24};
        adv(1);

        // Basic scan of 1234: digits 0..3 show 4,3,2,1.
        restart("t1234", 16'h1234);
        for (int k = 0; k < 4; k++) begin
            check_slot($sformatf("t1234/d%0d", k), an_tab[k], g1234[k]);
        end

        // Leading-zero blanking on 0070.
        lz_blank = 1'b1;
        restart("lz1", 16'h0070);
        check_slot("lz1/d0", 4'hE, 7'h01);
        check_slot("lz1/d1", 4'hD, 7'h0F);
        check_slot("lz1/d2", 4'hB, 7'h7F);
        check_slot("lz1/d3", 4'h7, 7'h7F);
        lz_blank = 1'b0;
        restart("lz0", 16'h0070);
        check_slot("lz0/d0", 4'hE, 7'h01);
        check_slot("lz0/d1", 4'hD, 7'h0F);
        check_slot("lz0/d2", 4'hB, 7'h01);
        check_slot("lz0/d3", 4'h7, 7'h01);

        // All-blank codes keep the anode scan running.
        restart("blank", 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            check_slot($sformatf("blank/d%0d", k), an_tab[k], 7'h7F);
        end

        // Blink digit 0: lit scans 0,1; dark 2,3; lit 4,5.
        blink_mask = 4'b0001;
        restart("blink", 16'h1234);
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 4; k++) begin
                check_slot($sformatf("blink/s%0d/d%0d", s, k), an_tab[k],
                           (k == 0 && (s == 2 || s == 3)) ? 7'h7F : g1234[k]);
            end
        end
        blink_mask = 4'b0000;

        // Load on the slot-wrap edge: the next slot already shows the new value.
        restart("wrapld", 16'h1234);
        adv(5);
        check("wrapld/pre_seg", 16'(seg_n), 16'h4C);
        load      = 1'b1;
        digits_in = 16'h5678;
        adv(1);
        load = 1'b0;
        check("wrapld/edge_seg", 16'(seg_n), 16'h4C);
        check("wrapld/edge_tick", 16'(scan_tick), 16'h1);
        adv(1);
        check("wrapld/new_seg", 16'(seg_n), 16'h0F);
        check("wrapld/new_an", 16'(an_n), 16'hF);
        adv(1);
        for (int k = 1; k < 4; k++) begin
            check_slot($sformatf("wrapld/d%0d", k), an_tab[k], g5678[k]);
        end
        check_slot("wrapld/d0", an_tab[0], g5678[0]);

        // Reset together with load mid-slot: reset wins, scan restarts at digit 0.
        adv(3);
        check("rstld/pre_an", 16'(an_n), 16'hD);
        reset     = 1'b1;
        load      = 1'b1;
        digits_in = 16'h9999;
        adv(1);
        check("rstld/an", 16'(an_n), 16'hF);
        check("rstld/seg", 16'(seg_n), 16'h7F);
        check("rstld/tick", 16'(scan_tick), 16'h0);
        reset = 1'b0;
        load  = 1'b0;
        adv(1);
        check("rstld/e1_an", 16'(an_n), 16'hF);
        check("rstld/e1_seg", 16'(seg_n), 16'h7F);
        adv(1);
        for (int k = 0; k < 4; k++) begin
            check_slot($sformatf("rstld/d%0d", k), an_tab[k], 7'h7F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
